// File: rtl/lcd_timed_controller.sv
// Avalon-MM slave for an HD44780-style character LCD with hardware-timed bus cycles.
// The CPU is stalled via waitrequest until each LCD cycle (and post-write gap) completes.
module lcd_timed_controller #(
  parameter int unsigned BUS_WIDTH     = 8,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned E_HIGH_CYCLES = 12,
  parameter int unsigned E_LOW_CYCLES  = 13,
  parameter int unsigned GAP_CYCLES    = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [7:0]           writedata,
  output logic [7:0]           readdata,
  output logic                 waitrequest,
  output logic                 LCD_E,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  inout  wire  [BUS_WIDTH-1:0] LCD_data
);

  localparam int unsigned MAX_SH  = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int unsigned MAX_LG  = (E_LOW_CYCLES > GAP_CYCLES) ? E_LOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_SH > MAX_LG) ? MAX_SH : MAX_LG;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_E_HIGH, S_E_LOW, S_GAP, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 nib_q, nib_d;
  logic                 wr_q, wr_n;
  logic [1:0]           addr_q, addr_n;
  logic [7:0]           wd_q, wd_n;
  logic [7:0]           rd_shift;
  logic                 sample_en;
  logic                 drive_q, drive_d;
  logic [BUS_WIDTH-1:0] dout_q, dout_d;
  logic                 e_d, rs_d, rw_d, wait_d;
  logic [7:0]           readdata_d;
  logic [7:0]           tx_byte;
  logic                 lat_en, lat_wr, in_cycle;

  assign LCD_data = drive_q ? dout_q : {BUS_WIDTH{1'bz}};

  // Next state, counter reload and registered-output next values
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    nib_d      = nib_q;
    lat_en     = 1'b0;
    lat_wr     = 1'b0;
    readdata_d = readdata;
    sample_en  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (write || read) begin
          lat_en = 1'b1;
          lat_wr = write;
          if (write ? address[0] : !address[0]) begin
            // Write to the read port or read of the write port: complete with no LCD cycle
            state_d = S_DONE;
            if (!write) readdata_d = 8'h00;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES);
            nib_d   = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(1)) begin
          state_d = S_E_HIGH;
          cnt_d   = CNT_W'(E_HIGH_CYCLES);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_E_HIGH: begin
        if (cnt == CNT_W'(1)) begin
          sample_en = !wr_q;
          state_d   = S_E_LOW;
          cnt_d     = CNT_W'(E_LOW_CYCLES);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_E_LOW: begin
        if (cnt == CNT_W'(1)) begin
          if ((BUS_WIDTH == 4) && !nib_q) begin
            nib_d   = 1'b1;
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES);
          end else if (wr_q && (GAP_CYCLES != 0)) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP_CYCLES);
          end else begin
            state_d = S_DONE;
            if (!wr_q) readdata_d = rd_shift;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(1)) state_d = S_DONE;
        else                  cnt_d   = cnt - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    addr_n = lat_en ? address : addr_q;
    wr_n   = lat_en ? lat_wr : wr_q;
    wd_n   = (lat_en && lat_wr) ? writedata : wd_q;

    // High nibble goes out first in 4-bit mode
    tx_byte  = (BUS_WIDTH == 4) ? (nib_d ? {4'h0, wd_n[3:0]} : {4'h0, wd_n[7:4]}) : wd_n;
    in_cycle = (state_d == S_SETUP) || (state_d == S_E_HIGH) || (state_d == S_E_LOW);
    e_d      = (state_d == S_E_HIGH);
    rs_d     = in_cycle ? addr_n[1] : 1'b0;
    rw_d     = in_cycle ? addr_n[0] : 1'b1;
    drive_d  = in_cycle && wr_n;
    dout_d   = BUS_WIDTH'(tx_byte);
    wait_d   = (state_d != S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      nib_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 2'b00;
      wd_q        <= 8'h00;
      rd_shift    <= 8'h00;
      drive_q     <= 1'b0;
      dout_q      <= '0;
      LCD_E       <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b1;
      readdata    <= 8'h00;
      waitrequest <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      nib_q       <= nib_d;
      wr_q        <= wr_n;
      addr_q      <= addr_n;
      wd_q        <= wd_n;
      drive_q     <= drive_d;
      dout_q      <= dout_d;
      LCD_E       <= e_d;
      LCD_RS      <= rs_d;
      LCD_RW      <= rw_d;
      readdata    <= readdata_d;
      waitrequest <= wait_d;
      if (sample_en) begin
        if (BUS_WIDTH == 4) rd_shift <= {rd_shift[3:0], 4'(LCD_data)};
        else                rd_shift <= 8'(LCD_data);
      end
    end
  end

endmodule

// File: doc/lcd_timed_controller.md
Name: lcd_timed_controller

Overview:
- Avalon-MM slave driving an HD44780-compatible character LCD.
- Generates the LCD bus timing in hardware: RS/RW setup, E pulse width, hold/cycle time and post-command gap. The CPU holds the bus via waitrequest until the LCD cycle completes.
- Supports an 8-bit or a 4-bit (two-nibble) LCD data bus.
- Sits between the Nios system interconnect and the board LCD pins. Same register map as the existing combinational LCD port, so driver software is unchanged.

Parameters:
- BUS_WIDTH, 8, LCD data pins in use: 8 (DB7..DB0) or 4 (DB7..DB4, nibble mode). Any other value is illegal.
- SETUP_CYCLES, 2, clk cycles RS/RW/data stable before E rises. Must be ≥1.
- E_HIGH_CYCLES, 12, clk cycles E is held high. Must be ≥1.
- E_LOW_CYCLES, 13, clk cycles E is held low after the pulse (hold plus cycle-time fill). Must be ≥1.
- GAP_CYCLES, 2000, idle clk cycles after every LCD write before completion (command execution time). 0 means no gap.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- address  in  2  bit0 = LCD RW (1 = LCD read), bit1 = LCD RS (1 = data register).
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  8  byte to send to the LCD.
- readdata  out  8  byte read from the LCD; valid in the cycle waitrequest is low.
- waitrequest  out  1  Avalon stall.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  LCD read/not-write.
- LCD_data  inout  BUS_WIDTH  LCD data bus; driven only during LCD write cycles, otherwise high-Z.

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Values while reset is asserted and in the cycle after it:
  - state IDLE
  - LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data high-Z
  - readdata=0, waitrequest=1
- States: IDLE, SETUP, E_HIGH, E_LOW, GAP, DONE.
- Common rules:
  - waitrequest=0 only in DONE, 1 in every other state.
  - readdata is registered and holds its value until the next read completes.
- IDLE:
  - If write, latch address and writedata. write wins over read if both are asserted (protocol violation, defined anyway).
  - Else if read, latch address.
  - Write with address[0]=1, or read with address[0]=0: no LCD cycle, go directly to DONE. readdata is unchanged for the write case and 0 for the read case.
  - Valid request: go to SETUP with nibble_sel=0.
- SETUP (SETUP_CYCLES cycles):
  - LCD_RS and LCD_RW come from the latched address; E=0.
  - On a write, LCD_data is driven with the current nibble or byte.
- E_HIGH (E_HIGH_CYCLES cycles):
  - E=1; RS, RW and data are held.
  - On a read, LCD_data is sampled on the last E_HIGH cycle.
- E_LOW (E_LOW_CYCLES cycles):
  - E=0; RS, RW and write data are held.
  - Afterwards: if BUS_WIDTH=4 and nibble_sel=0, set nibble_sel=1 and go to SETUP.
  - Else a write goes to GAP when GAP_CYCLES>0, otherwise to DONE; a read goes to DONE.
- GAP (GAP_CYCLES cycles): E=0, LCD_RW=1, bus released.
- DONE (1 cycle): waitrequest=0, readdata valid, then IDLE.
- Nibble mode:
  - High nibble first: writedata[7:4], then writedata[3:0].
  - Read data assembled as {first sample, second sample}.
  - GAP is applied only after the second nibble.
- 8-bit mode readdata is the byte sampled in E_HIGH.
- Latency for an LCD access, from the cycle the request is accepted in IDLE to DONE inclusive:
  - 8-bit: 1+SETUP+E_HIGH+E_LOW+GAP(write)+1 cycles.
  - Nibble mode: the SETUP+E_HIGH+E_LOW phase is counted twice.
- One down-counter, width clog2 of the largest parameter plus 1. It is loaded on every state entry and the state advances when it reaches 1.
- Request or address changes during a transfer are ignored; the latched values are used.
- A request dropped mid-transfer (protocol violation) still completes the LCD cycle.
- Reset asserted mid-transfer: the next cycle has E=0, bus high-Z and state IDLE. A truncated E pulse is acceptable.
- Outside SETUP/E_HIGH/E_LOW, LCD_RW=1 and LCD_data is high-Z.

Test Plan:
- Default parameters, write address=2, writedata=0x41. Required: RS=1, RW=0, data=0x41 two cycles before E rises; E high exactly 12 cycles; waitrequest low exactly once, 2029 cycles after accept.
- Read address=1 with the LCD model driving 0x80 (busy flag). Required: RS=0, RW=1, bus not driven by DUT, readdata=0x80 in the DONE cycle, total latency 29 cycles, no gap.
- BUS_WIDTH=4, write address=0, writedata=0xA5. Required: two E pulses carrying 0xA then 0x5 on LCD_data; single gap after the second pulse; one waitrequest-low cycle.
- Invalid accesses: write address=1 and read address=0. Required: no E pulse, waitrequest low on the 2nd cycle, readdata=0 for the read.
- Assert reset during E_HIGH of a write. Required: next cycle E=0, LCD_data high-Z, RW=1, waitrequest=1; a new write afterwards completes normally.
- GAP_CYCLES=0 with back-to-back writes. Required: every E pulse is preceded by ≥SETUP_CYCLES of stable RS/RW/data; E low between pulses is ≥E_LOW_CYCLES+SETUP_CYCLES+2.
